// File: rtl/perceptron_pkg.sv
// Shared types, defaults and saturating arithmetic for the perceptron trainer/evaluator pair.
package perceptron_pkg;

    typedef enum logic [1:0] {IDLE, EVAL, CHECK, UPDATE} state_t;

    localparam int N_IN_DEFAULT    = 8;
    localparam int W_WIDTH_DEFAULT = 8;
    localparam int T_WIDTH_DEFAULT = 16;
    localparam int THRESH_RESET    = 8;

    // Signed add clamped to the range of a signed 'width'-bit value (width <= 32).
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int width);
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = {a[31], a} + {b[31], b};
        hi  = (33'sd1 <<< (width - 1)) - 33'sd1;
        lo  = -(33'sd1 <<< (width - 1));
        if (sum > hi) begin
            sum = hi;
        end else if (sum < lo) begin
            sum = lo;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/perceptron_weight_file.sv
// Bank of N_IN signed weights with one index-addressed saturating read-modify-write port.
module perceptron_weight_file
    import perceptron_pkg::*;
#(
    parameter int N_IN    = N_IN_DEFAULT,
    parameter int W_WIDTH = W_WIDTH_DEFAULT,
    parameter int IDX_W   = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [IDX_W-1:0]            idx,
    input  logic signed [W_WIDTH+1:0]   delta,
    output logic [N_IN*W_WIDTH-1:0]     weights_out
);

    localparam logic signed [W_WIDTH+1:0] W_MAX = (W_WIDTH + 2)'((1 << (W_WIDTH - 1)) - 1);
    localparam logic signed [W_WIDTH+1:0] W_MIN = ~W_MAX;

    logic signed [W_WIDTH-1:0] w [N_IN];
    logic signed [W_WIDTH+1:0] cur;
    logic signed [W_WIDTH+1:0] sum;
    logic signed [W_WIDTH+1:0] clamped;

    // Two guard bits keep weight + delta exact before clamping.
    always_comb begin
        cur     = {{2{w[idx][W_WIDTH-1]}}, w[idx]};
        sum     = cur + delta;
        clamped = sum;
        if (sum > W_MAX) begin
            clamped = W_MAX;
        end else if (sum < W_MIN) begin
            clamped = W_MIN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_IN; i++) begin
                w[i] <= '0;
            end
        end else if (wr_en) begin
            w[idx] <= clamped[W_WIDTH-1:0];
        end
    end

    always_comb begin
        weights_out = '0;
        for (int i = 0; i < N_IN; i++) begin
            weights_out[i*W_WIDTH +: W_WIDTH] = w[i];
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Online perceptron training FSM: accepts labelled samples, waits for the evaluator result,
// then adjusts threshold and weights (one weight per cycle) on a misclassification.
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int N_IN       = N_IN_DEFAULT,
    parameter int W_WIDTH    = W_WIDTH_DEFAULT,
    parameter int T_WIDTH    = T_WIDTH_DEFAULT,
    parameter int LR         = 1,
    parameter int EVAL_LAT   = 1,
    parameter int CONV_COUNT = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sample_valid,
    output logic                        sample_ready,
    input  logic [N_IN-1:0]             sample_in,
    input  logic                        sample_exp,
    output logic [N_IN-1:0]             perc_in,
    input  logic                        result,
    output logic [N_IN*W_WIDTH-1:0]     weights_out,
    output logic signed [T_WIDTH-1:0]   thresh_out,
    output logic                        busy,
    output logic                        update_done,
    output logic                        mistake,
    output logic [15:0]                 mistake_cnt,
    output logic                        converged
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CNT_W = (EVAL_LAT > 0) ? $clog2(EVAL_LAT + 1) : 1;
    localparam int STR_W = $clog2(CONV_COUNT + 1);
    localparam logic signed [31:0]        LR32 = 32'(LR);
    localparam logic signed [W_WIDTH+1:0] LR_W = (W_WIDTH + 2)'(LR);

    state_t                     state;
    state_t                     state_nxt;
    logic [CNT_W-1:0]           wait_cnt;
    logic [IDX_W-1:0]           idx;
    logic [STR_W-1:0]           streak;
    logic                       exp_q;
    logic signed [T_WIDTH-1:0]  thresh;
    logic signed [T_WIDTH-1:0]  thresh_nxt;
    logic signed [W_WIDTH+1:0]  delta;
    logic                       accept;
    logic                       err_nz;
    logic                       last_idx;
    logic                       wr_en;

    assign sample_ready = (state == IDLE) && !update_done;
    assign busy         = (state != IDLE);
    assign accept       = sample_valid && sample_ready;
    assign err_nz       = exp_q ^ result;
    assign last_idx     = (idx == IDX_W'(N_IN - 1));
    assign thresh_out   = thresh;

    // Once a mistake is known, err is +1 exactly when the sample was labelled 1.
    assign delta      = exp_q ? LR_W : -LR_W;
    assign thresh_nxt = T_WIDTH'(sat_add(32'(thresh), exp_q ? -LR32 : LR32, T_WIDTH));
    assign wr_en      = (state == UPDATE) && perc_in[idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EVAL;
            EVAL:    if (wait_cnt <= CNT_W'(1)) state_nxt = CHECK;
            CHECK:   state_nxt = err_nz ? UPDATE : IDLE;
            UPDATE:  if (last_idx) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perc_in     <= '0;
            exp_q       <= 1'b0;
            wait_cnt    <= '0;
            idx         <= '0;
            streak      <= '0;
            converged   <= 1'b0;
            mistake_cnt <= '0;
            thresh      <= T_WIDTH'(THRESH_RESET);
            update_done <= 1'b0;
            mistake     <= 1'b0;
        end else begin
            update_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        perc_in  <= sample_in;
                        exp_q    <= sample_exp;
                        wait_cnt <= CNT_W'(EVAL_LAT);
                    end
                end
                EVAL: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - CNT_W'(1);
                end
                CHECK: begin
                    if (!err_nz) begin
                        if (streak != STR_W'(CONV_COUNT)) streak <= streak + STR_W'(1);
                        if (streak >= STR_W'(CONV_COUNT - 1)) converged <= 1'b1;
                        update_done <= 1'b1;
                        mistake     <= 1'b0;
                    end else begin
                        streak    <= '0;
                        converged <= 1'b0;
                        if (mistake_cnt != 16'hFFFF) mistake_cnt <= mistake_cnt + 16'd1;
                        thresh    <= thresh_nxt;
                        idx       <= '0;
                    end
                end
                UPDATE: begin
                    idx <= idx + IDX_W'(1);
                    if (last_idx) begin
                        update_done <= 1'b1;
                        mistake     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    perceptron_weight_file #(
        .N_IN    (N_IN),
        .W_WIDTH (W_WIDTH),
        .IDX_W   (IDX_W)
    ) u_weights (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .idx         (idx),
        .delta       (delta),
        .weights_out (weights_out)
    );

endmodule

// File: tb/tb_perceptron_trainer.sv
// Scoreboard bench for perceptron_trainer: a reference model predicts each sample's outcome at accept time.
module tb_perceptron_trainer;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  sample_in;
    logic        sample_exp;
    logic [7:0]  perc_in;
    logic        result;
    logic [63:0] weights_out;
    logic [15:0] thresh_out;
    logic        busy;
    logic        update_done;
    logic        mistake;
    logic [15:0] mistake_cnt;
    logic        converged;

    perceptron_trainer dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_in    (sample_in),
        .sample_exp   (sample_exp),
        .perc_in      (perc_in),
        .result       (result),
        .weights_out  (weights_out),
        .thresh_out   (thresh_out),
        .busy         (busy),
        .update_done  (update_done),
        .mistake      (mistake),
        .mistake_cnt  (mistake_cnt),
        .converged    (converged)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] si;
        bit         ex;
        bit         rs;
    } stim_t;

    typedef struct {
        logic [7:0]  si;
        bit          mis;
        logic [63:0] w;
        logic [15:0] t;
        logic [15:0] cnt;
        bit          conv;
        int          lat;
    } exp_t;

    stim_t stim_q[$];
    exp_t  sb[$];
    int    acc_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int both_hi = 0;

    int mw[8];
    int mt;
    int mcnt;
    int mstreak;
    bit mconv;

    function automatic int clampi(int v, int lo, int hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) mw[i] = 0;
        mt = 8;
        mcnt = 0;
        mstreak = 0;
        mconv = 0;
    endfunction

    function automatic exp_t model(stim_t s);
        exp_t e;
        int err;
        err = int'(s.ex) - int'(s.rs);
        if (err == 0) begin
            if (mstreak < 16) mstreak++;
            if (mstreak >= 16) mconv = 1;
            e.mis = 0;
            e.lat = 3;
        end else begin
            mstreak = 0;
            mconv = 0;
            if (mcnt < 65535) mcnt++;
            mt = clampi(mt - err, -32768, 32767);
            for (int i = 0; i < 8; i++)
                if (s.si[i]) mw[i] = clampi(mw[i] + err, -128, 127);
            e.mis = 1;
            e.lat = 11;
        end
        for (int i = 0; i < 8; i++) e.w[8*i +: 8] = 8'(mw[i]);
        e.si   = s.si;
        e.t    = 16'(mt);
        e.cnt  = 16'(mcnt);
        e.conv = mconv;
        return e;
    endfunction

    task automatic run_stream(input string name);
        int n;
        int sent;
        int got;
        int guard;
        int budget;
        int ac;
        bit took;
        stim_t cur;
        exp_t e;
        n = stim_q.size();
        sent = 0;
        got = 0;
        guard = 0;
        budget = 20 * n + 50;
        cur = stim_q.pop_front();
        sample_valid = 1'b1;
        sample_in = cur.si;
        sample_exp = cur.ex;
        while (got < n && guard < budget) begin
            took = 0;
            if (update_done && sample_ready) both_hi++;
            if (update_done) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL %s spurious update_done got 1 want no pending sample", name);
                end else begin
                    e = sb.pop_front();
                    ac = acc_q.pop_front();
                    if (mistake !== e.mis) begin n_err++; $display("FAIL %s#%0d mistake got %b want %b", name, got, mistake, e.mis); end
                    n_cmp++;
                    if (weights_out !== e.w) begin n_err++; $display("FAIL %s#%0d weights got %h want %h", name, got, weights_out, e.w); end
                    n_cmp++;
                    if (thresh_out !== e.t) begin n_err++; $display("FAIL %s#%0d thresh got %h want %h", name, got, thresh_out, e.t); end
                    n_cmp++;
                    if (mistake_cnt !== e.cnt) begin n_err++; $display("FAIL %s#%0d mistake_cnt got %0d want %0d", name, got, mistake_cnt, e.cnt); end
                    n_cmp++;
                    if (converged !== e.conv) begin n_err++; $display("FAIL %s#%0d converged got %b want %b", name, got, converged, e.conv); end
                    n_cmp++;
                    if (perc_in !== e.si) begin n_err++; $display("FAIL %s#%0d perc_in got %h want %h", name, got, perc_in, e.si); end
                    n_cmp++;
                    if (cyc - ac !== e.lat) begin n_err++; $display("FAIL %s#%0d latency got %0d want %0d", name, got, cyc - ac, e.lat); end
                end
                got++;
            end
            if (sample_valid && sample_ready) begin
                sb.push_back(model(cur));
                acc_q.push_back(cyc);
                result = cur.rs;
                sent++;
                took = 1;
            end
            @(posedge clk);
            #1;
            guard++;
            if (took) begin
                if (sent < n) begin
                    cur = stim_q.pop_front();
                    sample_in = cur.si;
                    sample_exp = cur.ex;
                end else begin
                    sample_valid = 1'b0;
                end
            end
        end
        sample_valid = 1'b0;
        n_cmp++;
        if (got !== n) begin n_err++; $display("FAIL %s timeout completions got %0d want %0d", name, got, n); end
        n_cmp++;
        if (sent !== n || sb.size() !== 0) begin
            n_err++;
            $display("FAIL %s accepts got %0d (pending %0d) want %0d (pending 0)", name, sent, sb.size(), n);
        end
        stim_q.delete();
        sb.delete();
        acc_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (weights_out !== 64'h0) begin n_err++; $display("FAIL reset weights got %h want 0", weights_out); end
        n_cmp++; if (thresh_out !== 16'd8) begin n_err++; $display("FAIL reset thresh got %h want 0008", thresh_out); end
        n_cmp++; if (sample_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL reset ready/busy got %b/%b want 1/0", sample_ready, busy); end
        n_cmp++; if (mistake_cnt !== 16'd0 || converged !== 1'b0) begin n_err++; $display("FAIL reset cnt/conv got %0d/%b want 0/0", mistake_cnt, converged); end
        n_cmp++; if (update_done !== 1'b0 || perc_in !== 8'h0) begin n_err++; $display("FAIL reset done/perc_in got %b/%h want 0/00", update_done, perc_in); end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_correct();
        stim_q.push_back('{si: 8'hFF, ex: 1'b0, rs: 1'b0});
        run_stream("correct");
        n_cmp++; if (weights_out !== 64'h0 || thresh_out !== 16'd8) begin n_err++; $display("FAIL correct_state w/t got %h/%h want 0/0008", weights_out, thresh_out); end
    endtask

    task automatic test_mistake();
        stim_q.push_back('{si: 8'b1010_0101, ex: 1'b1, rs: 1'b0});
        run_stream("mistake");
        n_cmp++; if (weights_out !== 64'h0100_0100_0001_0001) begin n_err++; $display("FAIL mistake_w got %h want 0100010000010001", weights_out); end
        n_cmp++; if (thresh_out !== 16'd7 || mistake_cnt !== 16'd1) begin n_err++; $display("FAIL mistake_t/cnt got %h/%0d want 0007/1", thresh_out, mistake_cnt); end
    endtask

    task automatic test_saturation();
        logic [15:0] t_before;
        for (int i = 0; i < 130; i++) stim_q.push_back('{si: 8'h01, ex: 1'b1, rs: 1'b0});
        run_stream("sat_up");
        n_cmp++; if (weights_out[7:0] !== 8'h7F) begin n_err++; $display("FAIL sat_w0 got %h want 7f", weights_out[7:0]); end
        t_before = thresh_out;
        stim_q.push_back('{si: 8'h01, ex: 1'b0, rs: 1'b1});
        run_stream("sat_down");
        n_cmp++; if (weights_out[7:0] !== 8'h7E) begin n_err++; $display("FAIL sat_w0_down got %h want 7e", weights_out[7:0]); end
        n_cmp++; if (thresh_out !== t_before + 16'd1) begin n_err++; $display("FAIL sat_thresh got %h want %h", thresh_out, t_before + 16'd1); end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        for (int i = 0; i < 24; i++) begin
            s.si = 8'($urandom);
            s.ex = 1'($urandom_range(0, 1));
            s.rs = 1'($urandom_range(0, 1));
            stim_q.push_back(s);
        end
        run_stream("b2b");
    endtask

    task automatic test_convergence();
        stim_t s;
        stim_q.push_back('{si: 8'h0F, ex: 1'b1, rs: 1'b0});
        for (int i = 0; i < 15; i++) begin
            s.si = 8'($urandom);
            s.ex = 1'($urandom_range(0, 1));
            s.rs = s.ex;
            stim_q.push_back(s);
        end
        run_stream("conv15");
        n_cmp++; if (converged !== 1'b0) begin n_err++; $display("FAIL conv_after15 got %b want 0", converged); end
        stim_q.push_back('{si: 8'h33, ex: 1'b1, rs: 1'b1});
        run_stream("conv16");
        n_cmp++; if (converged !== 1'b1) begin n_err++; $display("FAIL conv_after16 got %b want 1", converged); end
        stim_q.push_back('{si: 8'h80, ex: 1'b0, rs: 1'b1});
        run_stream("conv_break");
        n_cmp++; if (converged !== 1'b0) begin n_err++; $display("FAIL conv_break got %b want 0", converged); end
    endtask

    task automatic test_reset_mid();
        sample_valid = 1'b1;
        sample_in = 8'h3C;
        sample_exp = 1'b1;
        result = 1'b0;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got %b want 1", busy); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (weights_out !== 64'h0 || thresh_out !== 16'd8) begin n_err++; $display("FAIL mid_reset w/t got %h/%h want 0/0008", weights_out, thresh_out); end
        n_cmp++; if (sample_ready !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL mid_reset ready/busy got %b/%b want 1/0", sample_ready, busy); end
        n_cmp++; if (mistake_cnt !== 16'd0 || perc_in !== 8'h0) begin n_err++; $display("FAIL mid_reset cnt/perc_in got %0d/%h want 0/00", mistake_cnt, perc_in); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        stim_q.push_back('{si: 8'hC3, ex: 1'b0, rs: 1'b1});
        run_stream("post_reset");
    endtask

    initial begin
        reset = 1'b1;
        sample_valid = 1'b0;
        sample_in = 8'h0;
        sample_exp = 1'b0;
        result = 1'b0;
        test_reset();
        test_correct();
        test_mistake();
        test_saturation();
        test_back_to_back();
        test_convergence();
        test_reset_mid();
        n_cmp++;
        if (both_hi !== 0) begin n_err++; $display("FAIL ready_vs_done overlap cycles got %0d want 0", both_hi); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
